// File: rtl/seq_calculator.sv
// Sequential add/sub/mul/div unit with a start/done handshake.
// Multiply is shift-add and divide is restoring, one step per clock, W steps each.
module seq_calculator #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] res_lo,
    output logic [W-1:0] res_hi,
    output logic         dz
);

    localparam int CW = $clog2(W);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   res_hi_q, res_hi_d;
    logic [W-1:0]   res_lo_q, res_lo_d;
    logic           dz_q, dz_d;

    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic [W+1:0]   div_diff;
    logic [W-1:0]   iter_hi, iter_lo;
    logic [W:0]     add_sum;
    logic [2*W-1:0] sub_diff;

    // One multiply or divide step on {hi,lo}; mcand holds the multiplicand or divisor.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
        div_shift = {hi_q, lo_q[W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};
        iter_hi   = hi_q;
        iter_lo   = lo_q;
        if (op_q == OP_MUL) begin
            iter_hi = mul_sum[W:1];
            iter_lo = {mul_sum[0], lo_q[W-1:1]};
        end else if (div_diff[W+1]) begin
            iter_hi = div_shift[W-1:0];
            iter_lo = {lo_q[W-2:0], 1'b0};
        end else begin
            iter_hi = div_diff[W-1:0];
            iter_lo = {lo_q[W-2:0], 1'b1};
        end
    end

    always_comb begin
        add_sum  = {1'b0, a} + {1'b0, b};
        sub_diff = {{W{1'b0}}, a} - {{W{1'b0}}, b};

        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dz_d     = dz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d = op;
                    case (op)
                        OP_ADD: begin
                            {res_hi_d, res_lo_d} = {{(W-1){1'b0}}, add_sum};
                            dz_d    = 1'b0;
                            state_d = S_DONE;
                        end
                        OP_SUB: begin
                            {res_hi_d, res_lo_d} = sub_diff;
                            dz_d    = 1'b0;
                            state_d = S_DONE;
                        end
                        OP_DIV: begin
                            if (b == '0) begin
                                res_lo_d = '1;
                                res_hi_d = a;
                                dz_d     = 1'b1;
                                state_d  = S_DONE;
                            end else begin
                                mcand_d = b;
                                hi_d    = '0;
                                lo_d    = a;
                                cnt_d   = CW'(W-1);
                                state_d = S_RUN;
                            end
                        end
                        default: begin
                            mcand_d = a;
                            hi_d    = '0;
                            lo_d    = b;
                            cnt_d   = CW'(W-1);
                            state_d = S_RUN;
                        end
                    endcase
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                hi_d = iter_hi;
                lo_d = iter_lo;
                if (cnt_q == '0) begin
                    res_hi_d = iter_hi;
                    res_lo_d = iter_lo;
                    dz_d     = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dz_q     <= dz_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign res_hi = res_hi_q;
    assign res_lo = res_lo_q;
    assign dz     = dz_q;

endmodule

// File: doc/seq_calculator.md
Name: seq_calculator

Overview:
- Parametrised sequential arithmetic unit: add, subtract, multiply, divide on two unsigned W-bit operands.
- Single start/done handshake; full 2W-bit result.
- Multiply is iterative shift-add; divide is iterative restoring.
- Sits between the switch/button input logic and the LED output mux. It is the clocked, width-generic replacement for the combinational per-operation paths.

Parameters:
W, 4, operand width in bits (W >= 2); result is 2W bits.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on a rising clk edge while busy=0
op  input  2  00 add, 01 sub, 10 div, 11 mul; captured with start
a  input  W  operand A (dividend / multiplicand); captured with start
b  input  W  operand B (divisor / multiplier); captured with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when res_hi/res_lo/dz become valid
res_lo  output  W  add/sub/mul: low half of result; div: quotient
res_hi  output  W  add/sub/mul: high half of result; div: remainder
dz  output  1  divide-by-zero flag for the last completed operation

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, res_lo=0, res_hi=0, dz=0.
  - Internal operand, accumulator and counter registers cleared.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge k:
  - a, b, op are latched. Inputs are ignored after this until the next accepted start.
  - add/sub: next state DONE. Result is registered at edge k+1 with done=1 in that cycle. Latency 1.
  - div with b=0: same as add/sub (latency 1). res_lo = all ones, res_hi = a, dz=1.
  - mul, or div with b!=0: next state RUN. Counter loads W-1 and busy=1 from edge k+1.
- RUN:
  - One iteration per cycle; counter decrements.
  - When the counter is 0, next state is DONE with the result registered.
  - Total latency is W+1 edges after the accepting edge; done=1 for exactly that cycle.
  - busy=1 for W cycles.
- DONE: done=1 for one cycle, busy=0. Without start, next state is IDLE.
  - Outputs hold their last result until the next completion.
  - done=0 outside the completion cycle.
- start while busy=1 is ignored: no queuing, no error.
- start in the DONE cycle is accepted (back-to-back operation).
- Arithmetic (all unsigned inputs; {res_hi,res_lo} is the 2W-bit result):
  - add: a + b, zero-extended. res_hi[0] is the carry; all other res_hi bits are 0.
  - sub: a - b as a 2W-bit two's-complement value. If a<b, res_hi is all ones.
  - mul: full product a*b.
    - Shift-add: the LSB of the multiplier register selects adding the multiplicand into the upper accumulator, then the accumulator shifts right 1.
  - div: quotient into res_lo, remainder into res_hi.
    - Restoring: shift {rem,quo} left 1 and trial-subtract b.
    - If the subtraction does not borrow, keep the difference and set the quotient LSB.
    - Invariant: a = q*b + r, with r < b.
- dz is updated on every completion: it is 1 only for div with b=0, otherwise 0.
- Reset asserted mid-RUN aborts immediately to the reset values. No done pulse is produced for the aborted operation.

Test Plan (W=4):
- Reset, then add a=F, b=F, start at edge 0 -> edge 1: done=1, {res_hi,res_lo}=8'h1E, dz=0, busy never high.
- sub a=3, b=5 -> edge 1: {res_hi,res_lo}=8'hFE. Then sub a=9, b=2 -> 8'h07.
- mul a=F, b=F -> busy=1 for edges 1..4. Edge 5: done=1, {res_hi,res_lo}=8'hE1. mul a=0, b=7 -> 8'h00.
- div a=D, b=4 -> edge 5: res_lo=3, res_hi=1, dz=0. div a=9, b=0 -> edge 1: res_lo=F, res_hi=9, dz=1.
- Start mul a=2, b=3; at edge 2 pulse start with add a=1, b=1 -> ignored. Edge 5: result 8'h06 and only one done pulse.
- Start div a=F, b=2; drop rst_n at edge 3 -> all outputs 0 immediately, no done. Release rst_n, then add a=1, b=2 -> 8'h03 one cycle later.
